multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have these inputs: opcode  in  6  instruction[31:26] from instruction register; zero  in  1  ALU zero flag.
REQ-003 SHALL have these datapath outputs: PCEn  out  1  PC load enable; IorD  out  1  memory address select (1 = ALUOut); MemWrite  out  1  memory write; IRWrite  out  1  instruction register load.
REQ-004 SHALL have these register-file outputs: RegDst  out  1  write-register select (1 = rd); MemtoReg  out  1  write-data select (1 = MDR); RegWrite  out  1  register-file write.
REQ-005 SHALL have these ALU and PC outputs: ALUSrcA  out  1  (1 = regA); ALUSrcB  out  2  (00 regB, 01 const 4, 10 signext imm, 11 imm<<2); ALUOp  out  2  to ALU decoder (00 add, 01 sub, 10 funct); PCSrc  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-006 SHALL have these status outputs: illegal_op  out  1  unsupported opcode flag; state  out  4  current state, debug.

Function
REQ-007 SHALL be a Moore FSM with a 4-bit state register updated on rising clk; all outputs except PCEn depend on state only.
REQ-008 SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-009 SHALL sequence FETCH->DECODE unconditionally.
REQ-010 SHALL dispatch from DECODE on opcode: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX (see REQ-021); any other opcode -> FETCH.
REQ-011 SHALL sequence MEMADR->MEMRD when opcode=100011 and MEMADR->MEMWR when opcode=101011; MEMRD->MEMWB.
REQ-012 SHALL sequence EXECUTE->ALUWB and ADDIEX->ADDIWB.
REQ-013 SHALL return to FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
REQ-014 SHALL give each state its asserted outputs as listed; every unlisted output is 0: FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01. DECODE: ALUSrcB=11. MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
REQ-015 SHALL continue the per-state output table: MEMRD: IorD=1. MEMWB: MemtoReg=1, RegWrite=1. MEMWR: IorD=1, MemWrite=1. EXECUTE: ALUSrcA=1, ALUOp=10. ALUWB: RegDst=1, RegWrite=1. ADDIWB: RegWrite=1.
REQ-016 SHALL finish the per-state output table: BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1.
REQ-017 SHALL drive PCEn = PCWrite | (Branch & zero), combinationally, with PCWrite and Branch internal.
REQ-018 SHALL assert illegal_op only in DECODE when opcode is unsupported, for exactly one cycle, with no PC or register write caused by it.
REQ-019 SHALL complete each instruction in this many cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-020 SHALL load state=FETCH on a clk edge with reset=1, including mid-instruction; while in reset, outputs SHALL reflect FETCH except PCEn=0, IRWrite=0 (all writes are suppressed during reset); the first fetch occurs on the first cycle after reset deasserts.

Configuration
REQ-021 SHALL use macro MULTICYCLE_ADDI_EN as follows: if defined, opcode 001000 follows DECODE->ADDIEX->ADDIWB->FETCH; if undefined, states 9/10 are not generated, 001000 is treated as unsupported (REQ-018), and codes 9/10 behave as REQ-008 unused codes.

Verification
REQ-022 SHALL cover lw: reset, then opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5; PCEn=1 only in cycle 1.
REQ-023 SHALL cover beq taken/not taken: opcode=000100, zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUOp=01; repeat with zero=0 -> PCEn=0; next state FETCH in both.
REQ-024 SHALL cover R-type: opcode=000000 -> EXECUTE with ALUOp=10, ALUSrcA=1, ALUSrcB=00, then ALUWB with RegDst=1, RegWrite=1.
REQ-025 SHALL cover mid-instruction reset: reset=1 during MEMRD -> state=0 next edge, MemWrite=0, RegWrite=0, PCEn=0 while reset held.
REQ-026 SHALL cover illegal opcode: opcode=111111 -> illegal_op=1 for one DECODE cycle, then FETCH; opcode=001000 gives ADDIEX with macro defined, illegal_op=1 without it.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for a five-step multicycle MIPS-style datapath.
// Optional addi path (states ADDIEX/ADDIWB) enabled by MULTICYCLE_ADDI_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`endif
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  state_t r_state;
  state_t w_next;
  state_t w_dec;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_irwrite;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Reset forces FETCH decoding so no stale state can issue a write.
  assign w_dec = reset ? S_FETCH : r_state;

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    unique case (w_dec)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = 2'b01;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):   w_next = S_MEMADR;
          (opcode == OP_RTYP): w_next = S_EXECUTE;
          (opcode == OP_BEQ):  w_next = S_BRANCH;
          (opcode == OP_J):    w_next = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          (opcode == OP_ADDI): w_next = S_ADDIEX;
`endif
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
`endif
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCEn    = ~reset & (w_pcwrite | (w_branch & zero));
  assign IRWrite = ~reset & w_irwrite;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver queues expected
// per-cycle outputs from an instruction-path model, monitor compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic       ill;
  } out_t;

  typedef int path_t[$];

  out_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  // Output row for a state code, straight from the per-state table.
  function automatic out_t spec_row(int s, logic z, logic rst, logic ill);
    out_t o;
    logic pcw;
    logic br;
    o = '0; pcw = 1'b0; br = 1'b0;
    case (s)
      0: begin o.irw = 1'b1; pcw = 1'b1; o.asb = 2'b01; end
      1: begin o.asb = 2'b11; o.ill = ill; end
      2, 9: begin o.asa = 1'b1; o.asb = 2'b10; end
      3: o.iord = 1'b1;
      4: begin o.m2r = 1'b1; o.rw = 1'b1; end
      5: begin o.iord = 1'b1; o.mw = 1'b1; end
      6: begin o.asa = 1'b1; o.aop = 2'b10; end
      7: begin o.rdst = 1'b1; o.rw = 1'b1; end
      8: begin o.asa = 1'b1; o.aop = 2'b01; o.pcs = 2'b01; br = 1'b1; end
      10: o.rw = 1'b1;
      11: begin o.pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    o.pcen = pcw | (br & z);
    if (rst) begin o.pcen = 1'b0; o.irw = 1'b0; end
    return o;
  endfunction

  // Sequence of states an instruction visits, by opcode.
  function automatic path_t path(logic [5:0] op);
    path_t p;
    case (op)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b000010: p = '{0, 1, 11};
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: p = '{0, 1, 9, 10};
`endif
      default:   p = '{0, 1};
    endcase
    return p;
  endfunction

  task automatic cyc(input logic [5:0] op, input int s, input logic z,
                     input logic rst, input logic ill, input logic chk);
    out_t e;
    @(posedge clk);
    #1;
    opcode = op;
    zero   = z;
    reset  = rst;
    if (chk) begin
      e    = spec_row(rst ? 0 : s, z, rst, ill);
      e.st = s[3:0];
      q.push_back(e);
    end
  endtask

  // zmode: 0 random, 1 force zero=0, 2 force zero=1
  task automatic run_instr(input logic [5:0] op, input int zmode);
    path_t p;
    logic  z;
    p = path(op);
    foreach (p[i]) begin
      z = (zmode == 0) ? logic'($urandom_range(0, 1)) : (zmode == 2);
      cyc(op, p[i], z, 1'b0, (p.size() == 2) && (i == 1), 1'b1);
    end
  endtask

  always @(negedge clk) begin
    out_t a;
    out_t e;
    n_cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
            RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};
      n_chk++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs@state%0d op=%b z=%b rst=%b: got %h required %h",
                 e.st, opcode, zero, reset, a, e);
      end
    end
  end

  initial begin
    logic [5:0] legal[7];
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
              6'b000010, 6'b001000, 6'b111111};
    cyc(6'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(6'd0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_instr(6'b100011, 0);
    run_instr(6'b000100, 2);
    run_instr(6'b000100, 1);
    run_instr(6'b000000, 0);
    run_instr(6'b101011, 0);
    run_instr(6'b000010, 0);
    run_instr(6'b111111, 0);
    run_instr(6'b001000, 0);
    cyc(6'b100011, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(6'b100011, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(6'b100011, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(6'b100011, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(6'b100011, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(6'b000100, 2);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0)
        run_instr(6'($urandom_range(0, 63)), 0);
      else
        run_instr(legal[$urandom_range(0, 6)], 0);
    end
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
